// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared FSM state encoding and default width for serial_adder
package serial_adder_pkg;

  localparam int SA_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_fa.sv
// rtl/serial_adder_fa.sv - 1-bit full adder (fa) from two half-adder stages and an OR
module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  logic ha0_s;
  logic ha0_c;
  logic ha1_c;

  assign ha0_s = a ^ b;
  assign ha0_c = a & b;

  assign s     = ha0_s ^ cin;
  assign ha1_c = ha0_s & cin;

  assign co    = ha0_c | ha1_c;

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder; SERIAL_ADDER_OVF_EN adds the ovf output
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               done_q, done_d;
  logic               bit_s;
  logic               bit_c;
  logic               last_bit;
`ifdef SERIAL_ADDER_OVF_EN
  logic               cmsb_q, cmsb_d;
  logic               ovf_q, ovf_d;
`endif

  fa u_fa (
    .a   (a_sr_q[0]),
    .b   (b_sr_q[0]),
    .cin (carry_q),
    .s   (bit_s),
    .co  (bit_c)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
    cmsb_d  = cmsb_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        res_d   = {bit_s, res_q[WIDTH-1:1]};
        carry_d = bit_c;
        cnt_d   = cnt_q + 1'b1;
        if (last_bit) begin
`ifdef SERIAL_ADDER_OVF_EN
          // carry entering the MSB position, needed for signed overflow
          cmsb_d  = carry_q;
`endif
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // results are published together with the registered done pulse
        sum_d   = res_q;
        cout_d  = carry_q;
        done_d  = 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = cmsb_q ^ carry_q;
`endif
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      cmsb_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
      cmsb_q  <= cmsb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == ST_ADD);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
